// File: rtl/button_debounce_multi_if.sv
// Button debouncer bundle: tick enable and raw buttons in, debounced level
// and one-cycle strobes out. The master drives the inputs, the slave is the
// debouncer.
interface button_debounce_multi_if #(
    parameter int N_BTN = 4
);
    logic             slow_clk;
    logic [N_BTN-1:0] button_in;
    logic [N_BTN-1:0] level_out;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] repeat_pulse;

    modport master (
        output slow_clk,
        output button_in,
        input  level_out,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  slow_clk,
        input  button_in,
        output level_out,
        output press_pulse,
        output release_pulse,
        output repeat_pulse
    );
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel push-button debouncer: per channel a two-flop synchroniser,
// a tick-counted stability filter, and a hold counter for auto-repeat.
// All outputs are registered; pulses last one regular_clk cycle.
module button_debounce_multi #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 4,
    parameter int HOLD_TICKS   = 200,
    parameter int REPEAT_TICKS = 40,
    parameter int REPEAT_EN    = 1
) (
    input logic                        regular_clk,
    input logic                        reset,
    button_debounce_multi_if.slave     bus
);
    localparam int CNT_W  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_TICKS - REPEAT_TICKS);
    localparam logic              REPEAT_ON   = (REPEAT_EN != 0);

    logic [N_BTN-1:0]  sync_meta;
    logic [N_BTN-1:0]  sync_q;
    logic [N_BTN-1:0]  level_q;
    logic [N_BTN-1:0]  press_q;
    logic [N_BTN-1:0]  release_q;
    logic [N_BTN-1:0]  repeat_q;
    logic [N_BTN-1:0]  accept;
    logic [CNT_W-1:0]  cnt  [N_BTN];
    logic [HOLD_W-1:0] hold [N_BTN];

    // A channel accepts its new value on the tick that completes the stability run
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            accept[i] = bus.slow_clk && (sync_q[i] != level_q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Synchroniser, stability filter, hold/repeat counter and registered pulses
    always_ff @(posedge regular_clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt[i]  <= '0;
                hold[i] <= '0;
            end
        end else begin
            sync_meta <= bus.button_in;
            sync_q    <= sync_meta;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (bus.slow_clk) begin
                    if (sync_q[i] == level_q[i]) begin
                        cnt[i] <= '0;
                    end else if (!accept[i]) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end else begin
                        cnt[i]       <= '0;
                        level_q[i]   <= sync_q[i];
                        press_q[i]   <= sync_q[i];
                        release_q[i] <= ~sync_q[i];
                    end
                end

                // Reload to HOLD_TICKS-REPEAT_TICKS keeps the counter bounded so
                // a held button repeats indefinitely at the repeat period.
                if (!level_q[i] || accept[i]) begin
                    hold[i] <= '0;
                end else if (bus.slow_clk) begin
                    if (hold[i] == HOLD_MAX) begin
                        repeat_q[i] <= REPEAT_ON;
                        hold[i]     <= HOLD_RELOAD;
                    end else begin
                        hold[i] <= hold[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.level_out     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.repeat_pulse  = repeat_q;
endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: scripted phase table, hand-written latency,
// reset and simultaneity sequences, then random button activity, all checked
// cycle by cycle against a tick-history reference model.
module tb_button_debounce_multi;
    localparam int NB   = 2;
    localparam int ST   = 4;
    localparam int HOLD = 8;
    localparam int REP  = 3;
    localparam int TP   = 10;

    logic regular_clk = 1'b0;
    logic reset       = 1'b1;

    button_debounce_multi_if #(.N_BTN(NB)) bus_a ();
    button_debounce_multi_if #(.N_BTN(NB)) bus_b ();

    assign bus_b.slow_clk  = bus_a.slow_clk;
    assign bus_b.button_in = bus_a.button_in;

    button_debounce_multi #(
        .N_BTN(NB), .STABLE_TICKS(ST), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .REPEAT_EN(1)
    ) dut_a (
        .regular_clk(regular_clk), .reset(reset), .bus(bus_a)
    );

    button_debounce_multi #(
        .N_BTN(NB), .STABLE_TICKS(ST), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .REPEAT_EN(0)
    ) dut_b (
        .regular_clk(regular_clk), .reset(reset), .bus(bus_b)
    );

    always #5 regular_clk = ~regular_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: synchroniser pipeline, last ST tick samples per channel,
    // ticks elapsed since the accepted press.
    logic [NB-1:0] m_s1, m_s2, m_lvl, e_press, e_rel, e_rep;
    bit            m_hist [NB][$];
    int            m_k    [NB];

    int press_cnt [NB];
    int rel_cnt   [NB];
    int rep_cnt   [NB];
    int rep_b_cnt [NB];
    int press_at  [NB];

    typedef struct {
        logic [1:0] btn;
        int         ticks;
        logic [1:0] lvl;
        int         p0, p1, r0, r1, q0, q1;
    } row_t;

    row_t rows [$];

    function automatic row_t mk(input logic [1:0] b, input int t, input logic [1:0] l,
                                input int p0, input int p1, input int r0, input int r1,
                                input int q0, input int q1);
        row_t r;
        r.btn = b; r.ticks = t; r.lvl = l;
        r.p0 = p0; r.p1 = p1; r.r0 = r0; r.r1 = r1; r.q0 = q0; r.q1 = q1;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        e_press = '0; e_rel = '0; e_rep = '0;
        for (int ch = 0; ch < NB; ch++) begin
            m_hist[ch].delete();
            m_k[ch] = 0;
        end
    endtask

    task automatic model_step(input logic tick, input logic [NB-1:0] btn);
        bit all_diff;
        e_press = '0; e_rel = '0; e_rep = '0;
        if (tick) begin
            for (int ch = 0; ch < NB; ch++) begin
                m_hist[ch].push_back(m_s2[ch]);
                if (m_hist[ch].size() > ST) void'(m_hist[ch].pop_front());
                all_diff = (m_hist[ch].size() == ST);
                foreach (m_hist[ch][j]) if (m_hist[ch][j] == m_lvl[ch]) all_diff = 0;
                if (all_diff) begin
                    m_lvl[ch] = m_s2[ch];
                    if (m_s2[ch]) e_press[ch] = 1'b1;
                    else          e_rel[ch]   = 1'b1;
                    m_k[ch] = 0;
                end else if (m_lvl[ch]) begin
                    m_k[ch]++;
                    if (m_k[ch] >= HOLD && (m_k[ch] - HOLD) % REP == 0) e_rep[ch] = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < NB; ch++) begin
            press_cnt[ch] = 0; rel_cnt[ch] = 0; rep_cnt[ch] = 0; rep_b_cnt[ch] = 0;
            press_at[ch] = -1;
        end
    endtask

    // One clock: drive tick, advance model, compare both DUTs after the edge
    task automatic cycle();
        bus_a.slow_clk = ((cyc % TP) == TP - 1);
        model_step(bus_a.slow_clk, bus_a.button_in);
        @(posedge regular_clk);
        #1;
        check("dut_a outputs",
              int'({bus_a.level_out, bus_a.press_pulse, bus_a.release_pulse, bus_a.repeat_pulse}),
              int'({m_lvl, e_press, e_rel, e_rep}));
        check("dut_b outputs",
              int'({bus_b.level_out, bus_b.press_pulse, bus_b.release_pulse, bus_b.repeat_pulse}),
              int'({m_lvl, e_press, e_rel, 2'b00}));
        for (int ch = 0; ch < NB; ch++) begin
            press_cnt[ch] += int'(bus_a.press_pulse[ch]);
            rel_cnt[ch]   += int'(bus_a.release_pulse[ch]);
            rep_cnt[ch]   += int'(bus_a.repeat_pulse[ch]);
            rep_b_cnt[ch] += int'(bus_b.repeat_pulse[ch]);
            if (bus_a.press_pulse[ch] && press_at[ch] < 0) press_at[ch] = cyc;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   start;
        int   dur [NB];
        logic [NB-1:0] b;

        bus_a.slow_clk  = 1'b0;
        bus_a.button_in = '0;
        model_reset();
        clear_counts();

        rows.push_back(mk(2'b01,  5, 2'b01, 1, 0, 0, 0, 0, 0));  // clean press ch0
        rows.push_back(mk(2'b00,  5, 2'b00, 0, 0, 1, 0, 0, 0));  // short release
        rows.push_back(mk(2'b01,  5, 2'b01, 1, 0, 0, 0, 0, 0));  // press again
        rows.push_back(mk(2'b01, 20, 2'b01, 0, 0, 0, 0, 5, 0));  // auto-repeat
        rows.push_back(mk(2'b00,  5, 2'b00, 0, 0, 1, 0, 1, 0));  // release after long hold
        for (int k = 0; k < 5; k++) begin                         // bounce rejection
            rows.push_back(mk(2'b01, 3, 2'b00, 0, 0, 0, 0, 0, 0));
            rows.push_back(mk(2'b00, 1, 2'b00, 0, 0, 0, 0, 0, 0));
        end
        rows.push_back(mk(2'b11,  5, 2'b11, 1, 1, 0, 0, 0, 0));  // both channels
        rows.push_back(mk(2'b00,  5, 2'b00, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(2'b10,  5, 2'b10, 0, 1, 0, 0, 0, 0));  // ch1 alone
        rows.push_back(mk(2'b00,  5, 2'b00, 0, 0, 0, 1, 0, 0));

        repeat (3) @(posedge regular_clk);
        #1;
        check("reset state dut_a",
              int'({bus_a.level_out, bus_a.press_pulse, bus_a.release_pulse, bus_a.repeat_pulse}), 0);
        check("reset state dut_b",
              int'({bus_b.level_out, bus_b.press_pulse, bus_b.release_pulse, bus_b.repeat_pulse}), 0);
        @(negedge regular_clk);
        reset = 1'b0;

        for (int r = 0; r < rows.size(); r++) begin
            clear_counts();
            start = cyc;
            bus_a.button_in = rows[r].btn;
            run(rows[r].ticks * TP);
            check($sformatf("row%0d level", r),    int'(bus_a.level_out), int'(rows[r].lvl));
            check($sformatf("row%0d press0", r),   press_cnt[0], rows[r].p0);
            check($sformatf("row%0d press1", r),   press_cnt[1], rows[r].p1);
            check($sformatf("row%0d release0", r), rel_cnt[0],   rows[r].r0);
            check($sformatf("row%0d release1", r), rel_cnt[1],   rows[r].r1);
            check($sformatf("row%0d repeat0", r),  rep_cnt[0],   rows[r].q0);
            check($sformatf("row%0d repeat1", r),  rep_cnt[1],   rows[r].q1);
            check($sformatf("row%0d repeat_en0", r), rep_b_cnt[0] + rep_b_cnt[1], 0);
            if (r == 0) check("first press latency", press_at[0] - start, 4 * TP - 1);
            if (rows[r].btn == 2'b11) begin
                check("simultaneous press same cycle", press_at[1], press_at[0]);
                check("simultaneous press latency", press_at[0] - start, 4 * TP - 1);
            end
        end

        // Asynchronous reset while held, then re-acceptance of the still-held button
        bus_a.button_in = 2'b01;
        run(8 * TP);
        check("held before reset", int'(bus_a.level_out), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset dut_a",
              int'({bus_a.level_out, bus_a.press_pulse, bus_a.release_pulse, bus_a.repeat_pulse}), 0);
        check("async reset dut_b",
              int'({bus_b.level_out, bus_b.press_pulse, bus_b.release_pulse, bus_b.repeat_pulse}), 0);
        repeat (3) @(posedge regular_clk);
        #1;
        check("reset held dut_a",
              int'({bus_a.level_out, bus_a.press_pulse, bus_a.release_pulse, bus_a.repeat_pulse}), 0);
        model_reset();
        @(negedge regular_clk);
        reset = 1'b0;
        clear_counts();
        start = cyc;
        run(5 * TP);
        check("press after reset count", press_cnt[0], 1);
        check("press after reset latency", press_at[0] - start, 4 * TP - 1);
        check("level after reset", int'(bus_a.level_out), 1);

        // Random activity: mostly bounces, sometimes long holds to reach repeats
        for (int ch = 0; ch < NB; ch++) dur[ch] = 0;
        b = bus_a.button_in;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (dur[ch] == 0) begin
                    b[ch] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) dur[ch] = $urandom_range(100, 1200);
                    else                           dur[ch] = $urandom_range(1, 60);
                end
                dur[ch]--;
            end
            bus_a.button_in = b;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
